// File: rtl/clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// clk_freq_monitor
//
// Receiving-end check for the generated camera clock. Rising edges of the
// asynchronous monitored clock mon_in are counted over a fixed gate window of
// clk_in cycles. Each completed window publishes its count and compares it
// with EXPECTED +/- TOL (inclusive). clk_good asserts only after OK_WINDOWS
// consecutive in-range windows, so camera init can hold off until the clock
// has proven itself.
//
// mon_in must not exceed clk_in/3. A 24 MHz camera clock is monitored through
// a divide-by-2 toggle (12 MHz), which gives 12000 edges per 1 ms window.
//
// Optional feature (macro CLKFMON_STICKY_ERR_EN):
//   Adds input err_clr and output err_sticky. err_sticky latches any
//   out-of-range window until software clears it. A set in the same cycle as
//   a clear wins. Dropping en does not clear it. With the macro undefined,
//   neither port exists and no sticky logic is built.
//
// Output qualifier:
//   count_valid is a one-cycle pulse with no backpressure. It is high in
//   exactly the cycle in which count_out, freq_ok, stuck and clk_good first
//   show the result of a newly completed window; the consumer must take the
//   result in that cycle or read the held count_out/flags later.
//
// Debug:
//   state_dbg exposes the FSM state (0 = IDLE, 1 = MEASURE, 2 = EVAL).
// -----------------------------------------------------------------------------
module clk_freq_monitor #(
  parameter int GATE_CYCLES = 50000,
  parameter int EXPECTED    = 12000,
  parameter int TOL         = 60,
  parameter int OK_WINDOWS  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
`ifdef CLKFMON_STICKY_ERR_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             freq_ok,
  output logic             clk_good,
  output logic             stuck,
  output logic [1:0]       state_dbg
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_EVAL    = 2'd2;

  // Gate counter only needs to reach GATE_CYCLES-1.
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

  // Good-run counter saturates at OK_WINDOWS.
  localparam int RUN_W = (OK_WINDOWS > 0) ? $clog2(OK_WINDOWS + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(OK_WINDOWS);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  // Edge counter saturates instead of wrapping, so a runaway clock never
  // aliases back into the acceptance band.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Acceptance band in CNT_W+1-bit signed arithmetic. A lower bound that
  // would go negative (TOL > EXPECTED) is clamped to zero.
  localparam logic signed [CNT_W:0] LO_SIGNED = (CNT_W + 1)'(EXPECTED - TOL);
  localparam logic signed [CNT_W:0] HI_BOUND  = (CNT_W + 1)'(EXPECTED + TOL);
  localparam logic signed [CNT_W:0] LO_BOUND  = (LO_SIGNED < 0) ? '0 : LO_SIGNED;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic                 sync_meta;
  logic                 sync_out;
  logic                 sync_hist;
  logic                 mon_rise;

  logic [1:0]           state;
  logic [1:0]           state_next;

  logic [GATE_W-1:0]    gate_cnt;
  logic [CNT_W-1:0]     edge_cnt;
  logic [RUN_W-1:0]     run_cnt;
  logic [RUN_W-1:0]     run_next;

  logic                 measuring;
  logic                 abort;
  logic                 eval;
  logic                 gate_last;
  logic                 edge_sat;
  logic                 in_range;
  logic signed [CNT_W:0] cnt_s;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detect
  // ---------------------------------------------------------------------------

  // Two flops bring mon_in into clk_in; a third keeps the previous sample.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      sync_hist <= 1'b0;
    end else begin
      sync_meta <= mon_in;
      sync_out  <= sync_meta;
      sync_hist <= sync_out;
    end
  end

  assign mon_rise = sync_out & ~sync_hist;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign measuring = (state == ST_MEASURE) && en;
  assign abort     = (state == ST_MEASURE) && !en;
  assign eval      = (state == ST_EVAL);
  assign gate_last = (gate_cnt == GATE_LAST);
  assign edge_sat  = (edge_cnt == CNT_MAX);
  assign state_dbg = state;

  // Next-state decode: an en drop in MEASURE aborts the window; EVAL is
  // always exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (en) state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!en)            state_next = ST_IDLE;
        else if (gate_last) state_next = ST_EVAL;
      end
      ST_EVAL: begin
        state_next = en ? ST_MEASURE : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Range check of the finished window count and next good-run value.
  always_comb begin
    cnt_s    = $signed({1'b0, edge_cnt});
    in_range = (cnt_s >= LO_BOUND) && (cnt_s <= HI_BOUND);
    run_next = '0;
    if (in_range) begin
      run_next = (run_cnt == RUN_MAX) ? RUN_MAX : (run_cnt + RUN_ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Gate counter runs only while measuring; it is zero in IDLE and EVAL.
  always_ff @(posedge clk_in) begin
    if (rst || !measuring)  gate_cnt <= '0;
    else if (gate_last)     gate_cnt <= '0;
    else                    gate_cnt <= gate_cnt + GATE_ONE;
  end

  // Edge counter: counts detected rises during MEASURE (including the last
  // gate cycle), holds its total through EVAL, then clears.
  always_ff @(posedge clk_in) begin
    if (rst || !measuring)      edge_cnt <= '0;
    else if (mon_rise && !edge_sat) edge_cnt <= edge_cnt + CNT_ONE;
  end

  // ---------------------------------------------------------------------------
  // Published results
  // ---------------------------------------------------------------------------

  // Window result registers: loaded in EVAL, flags cleared on abort,
  // count_out held across aborts.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      freq_ok     <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      count_valid <= eval;
      if (eval) begin
        count_out <= edge_cnt;
        freq_ok   <= in_range;
        stuck     <= (edge_cnt == '0);
      end else if (abort) begin
        freq_ok   <= 1'b0;
        stuck     <= 1'b0;
      end
    end
  end

  // Good-run counter and clk_good: a bad window drops clk_good in the same
  // update that reports it.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      run_cnt  <= '0;
      clk_good <= 1'b0;
    end else if (eval) begin
      run_cnt  <= run_next;
      clk_good <= (run_next == RUN_MAX);
    end else if (abort) begin
      run_cnt  <= '0;
      clk_good <= 1'b0;
    end
  end

`ifdef CLKFMON_STICKY_ERR_EN
  // Sticky error: set by any out-of-range window, cleared by err_clr; a set
  // in the same cycle as a clear wins.
  always_ff @(posedge clk_in) begin
    if (rst)                    err_sticky <= 1'b0;
    else if (eval && !in_range) err_sticky <= 1'b1;
    else if (err_clr)           err_sticky <= 1'b0;
  end
`endif

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Receiving end of the generated camera clock path: checks that the derived clock actually arrives at the expected frequency.
- Counts rising edges of a monitored clock (`mon_in`) over a fixed gate window of the 50 MHz system clock.
- Publishes each count and compares it with an expected value ± tolerance.
- Asserts `clk_good` only after several consecutive in-range windows; downstream camera init logic holds off until then.
- `mon_in` is asynchronous to `clk_in` and must not exceed `clk_in`/3. The 24 MHz camera clock is monitored via a divide-by-2 toggle (12 MHz).

Parameters:
- GATE_CYCLES, 50000, gate window length in `clk_in` cycles (1 ms at 50 MHz).
- EXPECTED, 12000, expected rising-edge count per window.
- TOL, 60, allowed absolute deviation from EXPECTED (inclusive).
- OK_WINDOWS, 4, consecutive in-range windows required before `clk_good` asserts.
- CNT_W, 16, width of the edge counter and of `count_out`.

Ports:
- clk_in  input  1  system clock, 50 MHz
- rst  input  1  reset; single clock domain; reset is synchronous and active-high
- en  input  1  measurement enable
- mon_in  input  1  monitored clock, asynchronous to `clk_in`
- count_out  output  CNT_W  edge count of the last completed window
- count_valid  output  1  one-cycle pulse when `count_out` updates
- freq_ok  output  1  last window's count was in range
- clk_good  output  1  OK_WINDOWS consecutive in-range windows seen
- stuck  output  1  last window counted zero edges

Behaviour:
- Synchronizer and edge detect:
  - `mon_in` passes through a 2-FF synchronizer plus one history FF; all three reset to 0.
  - A rising edge is counted when synced=1 and history=0.
  - Pin-to-count latency is 3 cycles.
- Reset values: `count_out`=0, `count_valid`=0, `freq_ok`=0, `clk_good`=0, `stuck`=0. State=IDLE; all internal counters 0.
- State IDLE:
  - Gate and edge counters held at 0.
  - When `en`=1 is sampled, go to MEASURE.
- State MEASURE:
  - Gate counter increments every cycle.
  - Edge counter increments on each detected edge, saturating at 2^CNT_W-1 (no wrap).
  - An edge detected in the cycle where gate = GATE_CYCLES-1 is counted.
  - When gate = GATE_CYCLES-1, go to EVAL.
- State EVAL (exactly 1 cycle; edges in this cycle are not counted):
  - `count_out` <= edge count; `count_valid`=1 for this cycle only.
  - in_range = (count >= EXPECTED-TOL) && (count <= EXPECTED+TOL). Compute with CNT_W+1-bit signed arithmetic; a negative lower bound clamps to 0.
  - `freq_ok` <= in_range; `stuck` <= (count==0).
  - Good-run counter: if in_range, it increments, saturating at OK_WINDOWS; else it clears to 0.
  - `clk_good` <= (new run value == OK_WINDOWS). An out-of-range window drops `clk_good` in the same update.
  - Counters clear; go to MEASURE, or to IDLE if `en`=0.
- Window period is GATE_CYCLES+1 cycles. The first `count_valid` occurs GATE_CYCLES+1 cycles after the cycle in which `en` is first sampled high.
- `en` deasserted mid-window:
  - Next state is IDLE; the partial count is discarded.
  - `count_out` retains its last value.
  - `freq_ok`, `clk_good`, `stuck` and the good-run counter clear to 0; no `count_valid` pulse.
- `rst` mid-operation: all state returns to reset values on the next edge, regardless of state. `rst` has priority over `en`.

Optional Feature:
- Macro: CLKFMON_STICKY_ERR_EN.
- With the macro defined:
  - Adds input `err_clr` (1 bit) and output `err_sticky` (1 bit, reset 0).
  - `err_sticky` sets in any EVAL cycle where in_range=0.
  - It clears when `err_clr`=1, unless a set occurs in the same cycle: set wins.
  - `en` deassertion does not clear it.
- Without the macro: neither port exists and no sticky logic is built.

Test Plan:
- Nominal rate. Params GATE_CYCLES=100, EXPECTED=25, TOL=1, OK_WINDOWS=3; `mon_in` period 4 `clk_in` cycles → `count_valid` every 101 cycles with `count_out` in 24..26, `freq_ok`=1; `clk_good` rises on the 3rd EVAL.
- Wrong rate. Same params, `mon_in` period 8 → `count_out` ≈12–13, `freq_ok`=0, `clk_good` stays 0; on switching back to period 4, `clk_good` needs 3 fresh good windows.
- Stuck clock. `mon_in` held 0 after `clk_good`=1 → next EVAL gives `count_out`=0, `stuck`=1, `freq_ok`=0, `clk_good`=0 in the same cycle.
- Saturation. CNT_W=4, `mon_in` period 4, GATE_CYCLES=100 → `count_out`=15, no wrap to small values.
- Abort and reset. Drop `en` at gate=50 → no `count_valid`, flags cleared, `count_out` unchanged; re-enable → first `count_valid` exactly 101 cycles later. Assert `rst` mid-window → all outputs 0 on the next cycle.
- Sticky error (macro on). One bad window → `err_sticky`=1, persisting through good windows and `en`=0. `err_clr` pulse → 0. `err_clr` coinciding with a bad EVAL → remains 1.
